// File: rtl/sc_encoder_pipe.sv
// sc_encoder_pipe: range encoder with a 2-entry output FIFO. Codes 1..MAX_CODE
//   pass through; codes above MAX_CODE give 0 and are flagged and counted.
// Latency: 1 cycle from accept to out_valid. Throughput: 1 beat/cycle.
// Backpressure: out_ready=0 holds the head stable; the skid register absorbs
//   one more beat, then in_ready drops. in_ready depends only on registered state.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   enable, in_valid, encoder_in, in_ready   input beat handshake (enable=0 -> 0)
//   out_valid, out_ready, binary_out, out_miss   output beat handshake
//   clear_count, miss_count   saturating count of accepted out-of-range codes
module sc_encoder_pipe #(
  parameter int IN_WIDTH  = 4,
  parameter int MAX_CODE  = 6,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  encoder_in,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IN_WIDTH-1:0]  binary_out,
  output logic                 out_miss,
  input  logic                 clear_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam logic [IN_WIDTH-1:0] MAX_C = IN_WIDTH'(MAX_CODE);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q;
  logic [IN_WIDTH-1:0]   head_dat_q;
  logic                  head_miss_q;
  logic [IN_WIDTH-1:0]   skid_dat_q;
  logic                  skid_miss_q;
  logic [CNT_WIDTH-1:0]  miss_count_q;

  logic [IN_WIDTH-1:0]   res_dat_d;
  logic                  res_miss_d;
  logic                  accept;
  logic                  deliver;

  // Handshake flags decode straight from the registered state.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  // Encode the incoming beat; code 0 falls through the pass-through branch as 0.
  always_comb begin
    res_dat_d  = '0;
    res_miss_d = 1'b0;
    if (enable) begin
      if (encoder_in > MAX_C) begin
        res_miss_d = 1'b1;
      end else begin
        res_dat_d = encoder_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= EMPTY;
      head_dat_q  <= '0;
      head_miss_q <= 1'b0;
      skid_dat_q  <= '0;
      skid_miss_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            head_dat_q  <= res_dat_d;
            head_miss_q <= res_miss_d;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            // Head leaves and the new beat replaces it in the same cycle.
            head_dat_q  <= res_dat_d;
            head_miss_q <= res_miss_d;
          end else if (accept) begin
            skid_dat_q  <= res_dat_d;
            skid_miss_q <= res_miss_d;
            state_q     <= FULL;
          end else if (deliver) begin
            state_q     <= EMPTY;
          end
        end
        FULL: begin
          if (deliver) begin
            head_dat_q  <= skid_dat_q;
            head_miss_q <= skid_miss_q;
            state_q     <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  // Counted at acceptance; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      miss_count_q <= '0;
    end else if (clear_count) begin
      miss_count_q <= '0;
    end else if (accept && res_miss_d && (miss_count_q != {CNT_WIDTH{1'b1}})) begin
      miss_count_q <= miss_count_q + 1'b1;
    end
  end

  assign binary_out = head_dat_q;
  assign out_miss   = head_miss_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_sc_encoder_pipe.sv
// tb_sc_encoder_pipe: checks sc_encoder_pipe mapping, FIFO ordering, backpressure,
//   counter saturation/clear and mid-transfer reset against a scoreboard queue.
module tb_sc_encoder_pipe;

  typedef struct {
    logic       en;
    logic [3:0] code;
    logic [3:0] dat;
    logic       miss;
  } vec_t;

  typedef struct packed {
    logic [3:0] dat;
    logic       miss;
  } beat_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic       in_valid;
  logic [3:0] encoder_in;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] binary_out;
  logic       out_miss;
  logic       clear_count;
  logic [7:0] miss_count;

  logic       s_in_valid;
  logic [3:0] s_code;
  logic       s_in_ready;
  logic       s_out_valid;
  logic [3:0] s_binary_out;
  logic       s_out_miss;
  logic       s_clear;
  logic [1:0] s_miss_count;

  int    checks   = 0;
  int    failures = 0;
  beat_t sbq[$];
  int    mdl_cnt  = 0;
  bit    mon_en   = 0;
  bit    hold_vld = 0;
  beat_t held;
  logic [3:0] exp_dat;
  logic       exp_miss;
  bit    rnd_on   = 0;
  vec_t  vecs[19];
  int    sat_exp[7] = '{1, 2, 3, 3, 3, 0, 1};

  always #5 clk = ~clk;

  sc_encoder_pipe #(.IN_WIDTH(4), .MAX_CODE(6), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .resetn(resetn), .enable(enable), .in_valid(in_valid),
    .encoder_in(encoder_in), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .binary_out(binary_out), .out_miss(out_miss),
    .clear_count(clear_count), .miss_count(miss_count)
  );

  sc_encoder_pipe #(.IN_WIDTH(4), .MAX_CODE(6), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .resetn(resetn), .enable(1'b1), .in_valid(s_in_valid),
    .encoder_in(s_code), .in_ready(s_in_ready), .out_valid(s_out_valid),
    .out_ready(1'b1), .binary_out(s_binary_out), .out_miss(s_out_miss),
    .clear_count(s_clear), .miss_count(s_miss_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference mapping for IN_WIDTH=4, MAX_CODE=6.
  function automatic beat_t ref_map(input logic en, input logic [3:0] code);
    beat_t b;
    b.dat  = 4'd0;
    b.miss = 1'b0;
    if (en && code > 4'd6) b.miss = 1'b1;
    else if (en) b.dat = code;
    return b;
  endfunction

  // Scoreboard: decisions are taken on the falling edge, for the next rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid_vs_model", {31'd0, out_valid}, {31'd0, sbq.size() != 0});
      chk("in_ready_vs_model", {31'd0, in_ready}, {31'd0, sbq.size() < 2});
      chk("miss_count", {24'd0, miss_count}, mdl_cnt);
      if (hold_vld) begin
        chk("hold_dat", {28'd0, binary_out}, {28'd0, held.dat});
        chk("hold_miss", {31'd0, out_miss}, {31'd0, held.miss});
      end
      if (!resetn) begin
        sbq.delete();
        mdl_cnt  = 0;
        hold_vld = 0;
      end else begin
        hold_vld  = out_valid && !out_ready;
        held.dat  = binary_out;
        held.miss = out_miss;
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_delivery actual=%0h expected=none", binary_out);
          end else begin
            beat_t b;
            b = sbq.pop_front();
            chk("out_dat", {28'd0, binary_out}, {28'd0, b.dat});
            chk("out_miss", {31'd0, out_miss}, {31'd0, b.miss});
          end
        end
        if (in_valid && in_ready) begin
          sbq.push_back('{exp_dat, exp_miss});
          if (exp_miss && mdl_cnt < 255) mdl_cnt++;
        end
        if (clear_count) mdl_cnt = 0;
      end
    end
  end

  task automatic send(input logic en, input logic [3:0] code, input logic [3:0] ed,
                      input logic em);
    bit got = 0;
    int n = 0;
    in_valid = 1'b1; enable = en; encoder_in = code; exp_dat = ed; exp_miss = em;
    while (!got && n < 1000) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted code=%0d", code);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d expected=0 beats pending", sbq.size());
    end
  endtask

  initial begin
    beat_t rb;
    for (int i = 0; i < 16; i++) begin
      vecs[i].en   = 1'b1;
      vecs[i].code = 4'(i);
      vecs[i].dat  = (i >= 1 && i <= 6) ? 4'(i) : 4'd0;
      vecs[i].miss = (i > 6);
    end
    vecs[16] = '{1'b0, 4'd3, 4'd0, 1'b0};
    vecs[17] = '{1'b1, 4'd6, 4'd6, 1'b0};
    vecs[18] = '{1'b0, 4'd15, 4'd0, 1'b0};

    resetn = 1'b0; enable = 1'b0; in_valid = 1'b0; encoder_in = 4'd0;
    out_ready = 1'b1; clear_count = 1'b0; exp_dat = 4'd0; exp_miss = 1'b0;
    s_in_valid = 1'b0; s_code = 4'd9; s_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_binary_out", {28'd0, binary_out}, 0);
    chk("rst_out_miss", {31'd0, out_miss}, 0);
    chk("rst_miss_count", {24'd0, miss_count}, 0);
    mon_en = 1;
    @(posedge clk);
    #1;

    // Codes 0..15 back to back.
    for (int i = 0; i < 16; i++) send(vecs[i].en, vecs[i].code, vecs[i].dat, vecs[i].miss);
    wait_empty();
    chk("miss_count_after_sweep", {24'd0, miss_count}, 9);
    for (int i = 16; i < 19; i++) send(vecs[i].en, vecs[i].code, vecs[i].dat, vecs[i].miss);
    wait_empty();
    chk("miss_count_after_disabled", {24'd0, miss_count}, 9);

    // Backpressure: third beat must wait until the consumer drains.
    out_ready = 1'b0;
    send(1'b1, 4'd2, 4'd2, 1'b0);
    send(1'b1, 4'd5, 4'd5, 1'b0);
    @(negedge clk);
    chk("bp_in_ready_low", {31'd0, in_ready}, 0);
    chk("bp_head_dat", {28'd0, binary_out}, 2);
    @(posedge clk);
    #1;
    fork
      send(1'b1, 4'd4, 4'd4, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_empty();

    // Reset while FULL.
    out_ready = 1'b0;
    send(1'b1, 4'd7, 4'd0, 1'b1);
    send(1'b1, 4'd3, 4'd3, 1'b0);
    resetn = 1'b0;
    in_valid = 1'b1; encoder_in = 4'd9; enable = 1'b1;
    @(posedge clk);
    #1;
    resetn = 1'b1; in_valid = 1'b0;
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_in_ready", {31'd0, in_ready}, 1);
    chk("midrst_miss_count", {24'd0, miss_count}, 0);
    out_ready = 1'b1;
    send(1'b1, 4'd1, 4'd1, 1'b0);
    @(negedge clk);
    chk("post_rst_out_valid", {31'd0, out_valid}, 1);
    chk("post_rst_dat", {28'd0, binary_out}, 1);
    @(posedge clk);
    #1;
    wait_empty();

    // Counter saturation and clear-over-increment on the 2-bit instance.
    for (int i = 0; i < 7; i++) begin
      s_in_valid = 1'b1;
      s_clear = (i == 5);
      @(negedge clk);
      chk("sat_in_ready", {31'd0, s_in_ready}, 1);
      @(posedge clk);
      #1;
      chk("sat_count", {30'd0, s_miss_count}, sat_exp[i]);
    end
    s_in_valid = 1'b0;
    s_clear = 1'b0;
    @(negedge clk);
    chk("sat_out_miss", {31'd0, s_out_miss}, 1);
    chk("sat_out_dat", {28'd0, s_binary_out}, 0);
    @(posedge clk);
    #1;

    // Random traffic.
    rnd_on = 1;
    fork
      while (rnd_on) begin
        @(posedge clk);
        #1;
        if (rnd_on) out_ready = ($urandom % 2) == 1;
      end
    join_none
    for (int i = 0; i < 10000; i++) begin
      logic       en;
      logic [3:0] code;
      while (($urandom % 2) == 1) begin
        @(posedge clk);
        #1;
      end
      en   = ($urandom_range(0, 3) != 0);
      code = 4'($urandom_range(0, 15));
      rb   = ref_map(en, code);
      send(en, code, rb.dat, rb.miss);
    end
    rnd_on = 0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    wait_empty();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    failures++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
